serial_adder_8bit: RTL and testbench

Bit-serial adder, the sequential counterpart of the team's combinational 8-bit subtractor. It latches two WIDTH-bit operands on a start strobe and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop. It then presents SUM and CARRY_OUT with a one-cycle DONE pulse. It is used where area matters more than latency, and as a reference engine for checking the parallel arithmetic blocks.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/full_adder_1bit.sv | 14 +
 rtl/serial_adder_8bit.sv | 133 +++++++++++++
 tb/tb_serial_adder_8bit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared encodings and helpers for the bit-serial arithmetic engines.
// Latency: n/a (package). Backpressure: n/a.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell used by the serial datapath.
// Latency: combinational. Backpressure: none.
module full_adder_1bit (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder, LSB first; optional OVERFLOW port under SERIAL_ADDER_OVF_EN.
// Latency: START accepted at edge N -> DONE pulse after edge N+WIDTH.
// Backpressure: START is ignored while BUSY; accepted in IDLE or the DONE cycle.
module serial_adder_8bit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY_OUT,
    output logic             BUSY,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             DONE,
    output logic             OVERFLOW
`else
    output logic             DONE
`endif
);

    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // The final sum bit comes straight from the adder, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_cout;

    full_adder_1bit u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .CIN  (carry_q),
        .S    (fa_s),
        .COUT (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    res_sh_d = '0;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = (WIDTH-1)'({fa_s, res_sh_q} >> 1);
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    sum_d   = {fa_s, res_sh_q};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is still the carry into the MSB at this point.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign SUM       = sum_q;
    assign CARRY_OUT = cout_q;
    assign BUSY      = (state_q == ST_RUN);
    assign DONE      = (state_q == ST_DONE);
`ifdef SERIAL_ADDER_OVF_EN
    assign OVERFLOW  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Directed self-checking bench for serial_adder_8bit (WIDTH=8); OVERFLOW checks under SERIAL_ADDER_OVF_EN.
// Latency: n/a. Backpressure: n/a.
module tb_serial_adder_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [7:0] sum;
    logic       carry_out;
    logic       busy;
    logic       done;
`ifdef SERIAL_ADDER_OVF_EN
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_8bit #(.WIDTH(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .A         (a_in),
        .B         (b_in),
        .SUM       (sum),
        .CARRY_OUT (carry_out),
        .BUSY      (busy),
`ifdef SERIAL_ADDER_OVF_EN
        .DONE      (done),
        .OVERFLOW  (overflow)
`else
        .DONE      (done)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one addition, wait for DONE and check timing, result and the one-cycle pulse.
    task automatic do_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input logic exp_c);
        int lat;
        int busy_cnt;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start    = 1'b0;
        a_in     = ~a;
        b_in     = ~b;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, carry_out, exp_c);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_sum_hold"}, sum, exp_sum);
    endtask

    initial begin
        int lat;
        int n_done;
        int viol;
        int done_at [3];

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        chk("rst_sum", sum, 0);
        chk("rst_cout", carry_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        do_add("v02_01", 8'h02, 8'h01, 8'h03, 1'b0);
        do_add("vff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        do_add("vaa_55", 8'hAA, 8'h55, 8'hFF, 1'b0);
        do_add("vf0_0f", 8'hF0, 8'h0F, 8'hFF, 1'b0);
        do_add("vff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // START pulsed mid-run and operands changed: must be ignored.
        start = 1'b1;
        a_in  = 8'h0F;
        b_in  = 8'h01;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a_in  = 8'h00;
        b_in  = 8'hFF;
        tick();
        start = 1'b0;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        lat   = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 8);
        chk("ign_sum", sum, 8'h10);
        chk("ign_cout", carry_out, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("ign_extra_done", n_done, 0);

        // START held high: back-to-back results every 9 cycles.
        start  = 1'b1;
        a_in   = 8'h80;
        b_in   = 8'h80;
        tick();
        n_done = 0;
        viol   = 0;
        for (int cyc = 0; cyc < 60 && n_done < 3; cyc++) begin
            if (busy == done) viol++;
            if (done) begin
                done_at[n_done] = cyc;
                chk("b2b_sum", sum, 8'h00);
                chk("b2b_cout", carry_out, 1);
                n_done++;
                if (n_done == 3) start = 1'b0;
            end
            if (n_done < 3) tick();
        end
        chk("b2b_count", n_done, 3);
        chk("b2b_first", done_at[0], 8);
        chk("b2b_gap1", done_at[1] - done_at[0], 9);
        chk("b2b_gap2", done_at[2] - done_at[1], 9);
        chk("b2b_busy_vs_done", viol, 0);
        tick();
        chk("b2b_stop_busy", busy, 0);
        chk("b2b_stop_done", done, 0);

        // Reset during a run aborts it and clears the result.
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_sum", sum, 0);
        chk("abort_cout", carry_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) n_done++;
            tick();
        end
        chk("abort_no_done", n_done, 0);
        do_add("after_abort", 8'h12, 8'h34, 8'h46, 1'b0);

`ifdef SERIAL_ADDER_OVF_EN
        do_add("ovf_7f_01", 8'h7F, 8'h01, 8'h80, 1'b0);
        chk("ovf_7f_01_flag", overflow, 1);
        do_add("ovf_80_ff", 8'h80, 8'hFF, 8'h7F, 1'b1);
        chk("ovf_80_ff_flag", overflow, 1);
        do_add("ovf_02_01", 8'h02, 8'h01, 8'h03, 1'b0);
        chk("ovf_02_01_flag", overflow, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
